// File: rtl/add_slice_sequencer.sv
`default_nettype none
// =====================================================================
// add_slice_sequencer : sequences a W-bit add through an external 4-bit
// full adder, one slice per cycle, LSB slice first.        Rev 1.0
// =====================================================================
module add_slice_sequencer #(
   parameter int NSLICE = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4*NSLICE-1:0]   a_in,
   input  logic [4*NSLICE-1:0]   b_in,
   input  logic                  c_in,
   output logic [3:0]            a_o,
   output logic [3:0]            b_o,
   output logic                  cin_o,
   input  logic [3:0]            s_i,
   input  logic                  cout_i,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*NSLICE-1:0]   sum_o,
   output logic                  cout_o
);
   localparam int            W        = 4 * NSLICE;
   localparam int            IW       = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NSLICE - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   idx_q,   idx_d;
   logic [W-1:0]    a_q,     a_d;
   logic [W-1:0]    b_q,     b_d;
   logic            carry_q, carry_d;
   logic [W-1:0]    work_q,  work_d;
   logic [W-1:0]    sum_q,   sum_d;
   logic            cout_q,  cout_d;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      work_d  = work_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a_in;
               b_d     = b_in;
               carry_d = c_in;
               idx_d   = '0;
               state_d = ADD;
            end
         end
         ADD: begin
            work_d[{idx_q, 2'b00} +: 4] = s_i;
            carry_d = cout_i;
            // Partial sums stay in work_q so sum_o keeps the previous result until this job completes.
            if (idx_q == LAST_IDX) begin
               sum_d   = work_d;
               cout_d  = cout_i;
               state_d = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         work_q  <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         work_q  <= work_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign a_o       = (state_q == ADD) ? a_q[{idx_q, 2'b00} +: 4] : 4'h0;
   assign b_o       = (state_q == ADD) ? b_q[{idx_q, 2'b00} +: 4] : 4'h0;
   assign cin_o     = (state_q == ADD) ? carry_q : 1'b0;
   assign sum_o     = sum_q;
   assign cout_o    = cout_q;

endmodule
`default_nettype wire

// File: doc/add_slice_sequencer.md
ADD_SLICE_SEQUENCER -- requirements
Module: add_slice_sequencer

Interface
REQ-001 SHALL have parameter: NSLICE, 4, number of 4-bit slices per operand (operand width W = 4*NSLICE).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  operand request valid.
REQ-005 SHALL have port: in_ready  output  1  block can accept an operand request.
REQ-006 SHALL have port: a_in  input  W  operand A.
REQ-007 SHALL have port: b_in  input  W  operand B.
REQ-008 SHALL have port: c_in  input  1  carry-in of the wide add.
REQ-009 SHALL have port: a_o  output  4  slice of A driven to the external 4-bit full adder.
REQ-010 SHALL have port: b_o  output  4  slice of B driven to the external 4-bit full adder.
REQ-011 SHALL have port: cin_o  output  1  carry driven to the external adder.
REQ-012 SHALL have port: s_i  input  4  sum returned by the external adder (combinational, same cycle).
REQ-013 SHALL have port: cout_i  input  1  carry returned by the external adder.
REQ-014 SHALL have port: out_valid  output  1  result valid.
REQ-015 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-016 SHALL have port: sum_o  output  W  wide sum.
REQ-017 SHALL have port: cout_o  output  1  wide carry-out.

Function
REQ-018 SHALL implement FSM states IDLE, ADD, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-019 IDLE: on edge with in_valid=1, SHALL register a_in, b_in, c_in into operand/carry registers, clear slice index to 0, go to ADD; otherwise stay IDLE.
REQ-020 ADD: a_o/b_o SHALL be bits [4*idx+3:4*idx] of registered A/B; cin_o SHALL be the carry register (c_in for idx 0).
REQ-021 ADD: each edge SHALL write s_i into sum bits [4*idx+3:4*idx], load carry register with cout_i, increment idx; at idx = NSLICE-1 SHALL go to DONE instead of incrementing.
REQ-022 Outside ADD, a_o, b_o, cin_o SHALL be 0.
REQ-023 DONE: sum_o and cout_o (= final carry register) SHALL be held stable while out_valid=1 and out_ready=0.
REQ-024 DONE: on edge with out_ready=1 SHALL go to IDLE; sum_o/cout_o retain last value until next result.
REQ-025 Latency: accept edge at cycle k -> out_valid first high in cycle k+NSLICE+1 (NSLICE ADD cycles, registered transitions).
REQ-026 in_valid in ADD or DONE SHALL be ignored; a_in/b_in/c_in changes after acceptance SHALL not affect the result.
REQ-027 Result SHALL equal {cout_o,sum_o} = a_in + b_in + c_in, modulo 2^(W+1), all unsigned.
REQ-028 Back-to-back: a new request accepted at earliest the edge after the DONE->IDLE edge (one idle cycle between jobs).

Reset
REQ-029 Edge with rst_n=0 SHALL force IDLE from any state, abandoning any job in progress; after it in_ready=1, out_valid=0, sum_o=0, cout_o=0, a_o=b_o=0, cin_o=0, idx=0, carry=0.
REQ-030 Request presented on the same edge as rst_n=0 SHALL be discarded.

Verification
REQ-031 a_in=0x0001, b_in=0xFFFF, c_in=0 -> sum_o=0x0000, cout_o=1, out_valid 5 cycles after accept edge.
REQ-032 a_in=0x1234, b_in=0x4321, c_in=1 -> a_o sequence 4,3,2,1, b_o 1,2,3,4, sum_o=0x5556, cout_o=0.
REQ-033 a_in=0xFFFF, b_in=0xFFFF, c_in=1 -> cin_o=1 every ADD cycle, sum_o=0xFFFF, cout_o=1.
REQ-034 out_ready=0 for 6 cycles in DONE -> out_valid, sum_o, cout_o constant, in_ready=0, new in_valid ignored.
REQ-035 rst_n=0 during second ADD cycle -> next cycle IDLE, in_ready=1, outputs at reset values, then a fresh 0x0002+0x0003 gives 0x0005.
REQ-036 Two consecutive requests with in_valid held high -> two correct results, one idle cycle between, no request lost or duplicated.
